// File: rtl/add_sub_64_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit carry-look-ahead slice per
// clock, with the slice carry-out registered and chained into the next slice.
module add_sub_64_serial #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; once the result is offered, out_valid and result/flags stay stable until
    // out_ready is seen.

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_g;
    logic [SLICE-1:0] sl_p;
    logic [SLICE:0]   cc;
    logic [SLICE-1:0] sl_sum;
    logic             sl_cout;
    logic             acc;
    logic             prod;
    logic [WIDTH-1:0] res_next;

    assign state_dbg = state;

    // Each carry is a flat sum of generate terms gated by propagate runs, so no
    // carry depends on a previously computed carry of the same slice.
    always_comb begin
        sl_a  = a_r[idx*SLICE +: SLICE];
        sl_b  = b_r[idx*SLICE +: SLICE];
        sl_g  = sl_a & sl_b;
        sl_p  = sl_a ^ sl_b;
        cc    = '0;
        cc[0] = c_r;
        acc   = 1'b0;
        prod  = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            acc  = sl_g[i];
            prod = sl_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & sl_g[j]);
                prod = prod & sl_p[j];
            end
            cc[i+1] = acc | (prod & c_r);
        end
        sl_sum   = sl_p ^ cc[SLICE-1:0];
        sl_cout  = cc[SLICE];
        res_next = result;
        res_next[idx*SLICE +: SLICE] = sl_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= op_a;
                        b_r      <= sub ? ~op_b : op_b;
                        c_r      <= sub;
                        idx      <= '0;
                        result   <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result <= res_next;
                    c_r    <= sl_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        carry     <= sl_cout;
                        overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (sl_sum[SLICE-1] != a_r[WIDTH-1]);
                        zero      <= (res_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_64_serial.sv
// Directed bench for add_sub_64_serial: arithmetic vectors, latency, backpressure,
// back-to-back operation and asynchronous reset in the middle of a run.
module tb_add_sub_64_serial;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic [1:0]  state_dbg;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    add_sub_64_serial dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: all stimulus changes #1 after a rising edge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        sub      = ~s;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        logic keep;
        keep      = out_ready;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = keep;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during got %b expected 1", in_ready);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
        if (result !== 64'h0 || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0)
            $display("FAIL reset_outputs got result=%h c=%b v=%b z=%b expected all zero",
                     result, carry, overflow, zero);
        else n_pass++;
    endtask

    task automatic test_arith();
        int lat;
        vecs[0] = '{64'h00000000000000FF, 64'h1, 1'b0, 64'h0000000000000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h8000000000000000, 64'h1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{64'h5, 64'h7, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{64'h00FF00FF00FF00FF, 64'h0001000100010001, 1'b0, 64'h0100010001000100, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL arith[%0d] in_ready got %b expected 1", k, in_ready);
            else n_pass++;
            start_op(vecs[k].a, vecs[k].b, vecs[k].s);
            wait_done(lat);
            n_checks++;
            if (lat !== 8) $display("FAIL arith[%0d] latency got %0d expected 8", k, lat);
            else n_pass++;
            n_checks++;
            if (result !== vecs[k].r)
                $display("FAIL arith[%0d] result got %h expected %h", k, result, vecs[k].r);
            else n_pass++;
            n_checks++;
            if ({carry, overflow, zero} !== {vecs[k].c, vecs[k].v, vecs[k].z})
                $display("FAIL arith[%0d] flags cvz got %b%b%b expected %b%b%b", k,
                         carry, overflow, zero, vecs[k].c, vecs[k].v, vecs[k].z);
            else n_pass++;
            drain();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL arith[%0d] release got out_valid=%b in_ready=%b expected 0/1",
                         k, out_valid, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        start_op(64'h3, 64'h4, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== 8 || result !== 64'h7)
            $display("FAIL bp_first got lat=%0d result=%h expected 8/%h", lat, result, 64'h7);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                op_a     = 64'h100;
                op_b     = 64'h200;
                sub      = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h7 ||
                carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b res=%h cvz=%b%b%b expected 1/0/%h/000",
                         i, out_valid, in_ready, result, carry, overflow, zero, 64'h7);
                bad++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL bp_stall_cycles got %0d bad cycles expected 0", bad);
        else n_pass++;
        drain();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'h7)
            $display("FAIL bp_release got ov=%b ir=%b res=%h expected 0/1/%h",
                     out_valid, in_ready, result, 64'h7);
        else n_pass++;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_ignored_op got %0d valid cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        start_op(64'h10, 64'h20, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== 8 || result !== 64'h30)
            $display("FAIL b2b_first got lat=%0d result=%h expected 8/%h", lat, result, 64'h30);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_release got ov=%b ir=%b expected 0/1", out_valid, in_ready);
        else n_pass++;
        start_op(64'h10, 64'h20, 1'b1);
        wait_done(lat);
        n_checks++;
        if (lat !== 8 || result !== 64'hFFFFFFFFFFFFFFF0 || carry !== 1'b0)
            $display("FAIL b2b_second got lat=%0d result=%h c=%b expected 8/%h/0",
                     lat, result, carry, 64'hFFFFFFFFFFFFFFF0);
        else n_pass++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bad;
        start_op(64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 64'h0 || in_ready !== 1'b1)
            $display("FAIL midrun_reset got ov=%b res=%h ir=%b expected 0/0/1",
                     out_valid, result, in_ready);
        else n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL midrun_no_valid got %0d valid cycles expected 0", bad);
        else n_pass++;
        start_op(64'h1, 64'h1, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== 8 || result !== 64'h2 || carry !== 1'b0 || zero !== 1'b0)
            $display("FAIL midrun_after got lat=%0d result=%h c=%b z=%b expected 8/2/0/0",
                     lat, result, carry, zero);
        else n_pass++;
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
